// File: rtl/point_cloud_bbox.sv
// Axis-aligned bounding box of one frame of signed 16-bit points read from a BRAM.
// Produces the packed near/far/mid corner words consumed by the octree core.
module point_cloud_bbox #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 16,
  parameter int SIZE_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [SIZE_W-1:0] i_point_cloud_size,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [47:0]       i_rd_data,
  output logic [63:0]       o_near_bottom_left,
  output logic [63:0]       o_far_top_right,
  output logic [63:0]       o_mid_point,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_state
);

  // Handshake: i_start is a one-cycle request honoured only in IDLE; o_done is a
  // one-cycle pulse after which the three corner words stay stable until the next start.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_MID   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [SIZE_W-1:0]       r_remain;
  logic [ADDR_W-1:0]       r_addr;
  logic [1:0]              r_drain;
  logic [RD_LATENCY-1:0]   r_tag;
  logic                    r_first;
  logic signed [15:0]      r_min [3];
  logic signed [15:0]      r_max [3];
  logic [47:0]             r_near;
  logic [47:0]             r_far;
  logic [47:0]             r_mid;
  logic signed [15:0]      w_pt  [3];
  logic [16:0]             w_sum [3];
  logic [47:0]             w_mid;
  logic                    w_rd_en;

  assign w_rd_en = (r_state == S_READ);

  // Axis 0 is x in the top field, axis 2 is z in the bottom field.
  always_comb begin
    w_pt[0] = i_rd_data[47:32];
    w_pt[1] = i_rd_data[31:16];
    w_pt[2] = i_rd_data[15:0];
  end

  // 17-bit sign-extended sum cannot overflow; dropping bit 0 is an arithmetic shift (floor).
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_sum[a] = {r_min[a][15], r_min[a]} + {r_max[a][15], r_max[a]};
    end
    w_mid = {w_sum[0][16:1], w_sum[1][16:1], w_sum[2][16:1]};
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = (i_point_cloud_size == '0) ? S_DONE : S_READ;
      S_READ:  if (r_remain == '0) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == DRAIN_LAST) w_next = S_MID;
      S_MID:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_remain <= '0;
      r_addr   <= '0;
      r_drain  <= '0;
      r_tag    <= '0;
      r_first  <= 1'b1;
      r_near   <= '0;
      r_far    <= '0;
      r_mid    <= '0;
      for (int a = 0; a < 3; a++) begin
        r_min[a] <= '0;
        r_max[a] <= '0;
      end
    end else begin
      r_state <= w_next;

      r_tag[0] <= w_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end

      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_remain <= i_point_cloud_size - SIZE_W'(1);
            r_addr   <= '0;
            r_first  <= 1'b1;
            if (i_point_cloud_size == '0) begin
              r_near <= '0;
              r_far  <= '0;
              r_mid  <= '0;
            end
          end
        end
        S_READ: begin
          r_drain <= '0;
          // The address stays on N-1 after the last read is issued.
          if (r_remain != '0) begin
            r_remain <= r_remain - SIZE_W'(1);
            r_addr   <= r_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: r_drain <= r_drain + 2'd1;
        S_MID: begin
          r_near <= {r_min[0], r_min[1], r_min[2]};
          r_far  <= {r_max[0], r_max[1], r_max[2]};
          r_mid  <= w_mid;
        end
        default: ;
      endcase

      // A tag leaving the pipeline marks i_rd_data as a real point of this frame.
      if (r_tag[RD_LATENCY-1]) begin
        r_first <= 1'b0;
        for (int a = 0; a < 3; a++) begin
          if (r_first) begin
            r_min[a] <= w_pt[a];
            r_max[a] <= w_pt[a];
          end else begin
            if (w_pt[a] < r_min[a]) r_min[a] <= w_pt[a];
            if (w_pt[a] > r_max[a]) r_max[a] <= w_pt[a];
          end
        end
      end
    end
  end

  assign o_rd_en            = w_rd_en;
  assign o_rd_addr          = r_addr;
  assign o_busy             = (r_state != S_IDLE);
  assign o_done             = (r_state == S_DONE);
  assign o_state            = r_state;
  assign o_near_bottom_left = {r_near, 16'h0000};
  assign o_far_top_right    = {r_far, 16'h0000};
  assign o_mid_point        = {r_mid, 16'h0000};

endmodule

// File: tb/tb_point_cloud_bbox.sv
// Bench for point_cloud_bbox: two instances (read latency 1 and 3) share a point memory,
// each scan is compared with a min/max/floor-average reference computed from that memory.
module tb_point_cloud_bbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic [15:0] size;
  int          sel;
  int          n_checks;
  int          n_fail;
  logic [47:0] mem [0:255];

  logic        start0, start1;
  logic        rd_en0, rd_en1;
  logic [15:0] addr0, addr1;
  logic [47:0] rdata0, rdata1;
  logic [63:0] near0, near1, far0, far1, mid0, mid1;
  logic        busy0, busy1, done0, done1;
  logic [2:0]  state0, state1;
  logic [47:0] p3_a, p3_b;

  assign start0 = start & (sel == 0);
  assign start1 = start & (sel == 1);

  point_cloud_bbox #(.RD_LATENCY(1), .ADDR_W(16), .SIZE_W(16)) u_l1 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_point_cloud_size(size),
    .o_rd_en(rd_en0), .o_rd_addr(addr0), .i_rd_data(rdata0),
    .o_near_bottom_left(near0), .o_far_top_right(far0), .o_mid_point(mid0),
    .o_busy(busy0), .o_done(done0), .o_state(state0)
  );

  point_cloud_bbox #(.RD_LATENCY(3), .ADDR_W(16), .SIZE_W(16)) u_l3 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_point_cloud_size(size),
    .o_rd_en(rd_en1), .o_rd_addr(addr1), .i_rd_data(rdata1),
    .o_near_bottom_left(near1), .o_far_top_right(far1), .o_mid_point(mid1),
    .o_busy(busy1), .o_done(done1), .o_state(state1)
  );

  // BRAM models: junk on the data bus whenever no read is outstanding.
  always @(posedge clk) begin
    rdata0 <= rd_en0 ? mem[addr0[7:0]] : {16'($urandom), $urandom};
    p3_a   <= rd_en1 ? mem[addr1[7:0]] : {16'($urandom), $urandom};
    p3_b   <= p3_a;
    rdata1 <= p3_b;
  end

  logic        m_rd_en, m_busy, m_done;
  logic [15:0] m_addr;
  logic [63:0] m_near, m_far, m_mid;
  logic [2:0]  m_state;
  always_comb begin
    if (sel == 0) begin
      m_rd_en = rd_en0; m_addr = addr0; m_busy = busy0; m_done = done0;
      m_near = near0; m_far = far0; m_mid = mid0; m_state = state0;
    end else begin
      m_rd_en = rd_en1; m_addr = addr1; m_busy = busy1; m_done = done1;
      m_near = near1; m_far = far1; m_mid = mid1; m_state = state1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pt(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction

  function automatic int floor_half(input int s);
    return (s >= 0) ? s / 2 : -((1 - s) / 2);
  endfunction

  // Reference: bounding box over mem[0..n-1], mid = floor((min+max)/2) per axis.
  task automatic model(input int n, output logic [63:0] e_near, output logic [63:0] e_far,
                       output logic [63:0] e_mid);
    int mn [3];
    int mx [3];
    logic signed [15:0] v;
    e_near = '0; e_far = '0; e_mid = '0;
    if (n == 0) return;
    for (int i = 0; i < n; i++) begin
      for (int a = 0; a < 3; a++) begin
        v = mem[i][47-16*a -: 16];
        if (i == 0) begin
          mn[a] = v; mx[a] = v;
        end else begin
          if (v < mn[a]) mn[a] = v;
          if (v > mx[a]) mx[a] = v;
        end
      end
    end
    e_near = {16'(mn[0]), 16'(mn[1]), 16'(mn[2]), 16'h0000};
    e_far  = {16'(mx[0]), 16'(mx[1]), 16'(mx[2]), 16'h0000};
    e_mid  = {16'(floor_half(mn[0] + mx[0])), 16'(floor_half(mn[1] + mx[1])),
              16'(floor_half(mn[2] + mx[2])), 16'h0000};
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_en"}, 64'(m_rd_en), 64'd0);
    check({tag, "_addr"},  64'(m_addr), 64'd0);
    check({tag, "_busy"},  64'(m_busy), 64'd0);
    check({tag, "_done"},  64'(m_done), 64'd0);
    check({tag, "_near"},  m_near, 64'd0);
    check({tag, "_far"},   m_far, 64'd0);
    check({tag, "_mid"},   m_mid, 64'd0);
    check({tag, "_state"}, 64'(m_state), 64'd0);
  endtask

  // One frame on instance inst. ext_start_at pulses i_start at that cycle after E0;
  // rst_at asserts reset at that cycle and checks the cleared state one cycle later.
  task automatic run_scan(input int inst, input int n, input int ext_start_at,
                          input int rst_at, input string tag);
    int lat, exp_done, done_at, rd_cnt, busy_bad, addr_bad, late_rd;
    logic [63:0] e_near, e_far, e_mid;
    lat = (inst == 0) ? 1 : 3;
    exp_done = (n == 0) ? 1 : n + lat + 2;
    done_at = 0; rd_cnt = 0; busy_bad = 0; addr_bad = 0; late_rd = 0;
    model(n, e_near, e_far, e_mid);
    sel = inst;
    @(negedge clk);
    start = 1'b1;
    size  = 16'(n);
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      start = 1'b0;
      size  = 16'($urandom);
      if (rst_at != 0 && j == rst_at + 1) begin
        check_idle_zero({tag, "_after_rst"});
        rst = 1'b0;
        return;
      end
      if (m_rd_en === 1'b1) begin
        if (m_addr !== 16'(rd_cnt)) addr_bad++;
        if (j > n) late_rd++;
        rd_cnt++;
      end
      if (m_busy !== 1'b1) busy_bad++;
      if (j == ext_start_at) start = 1'b1;
      if (j == rst_at) rst = 1'b1;
      if (m_done === 1'b1) begin
        done_at = j;
        break;
      end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'(n));
    check({tag, "_addr_seq_errs"}, 64'(addr_bad), 64'd0);
    check({tag, "_rd_outside_window"}, 64'(late_rd), 64'd0);
    check({tag, "_busy_gaps"}, 64'(busy_bad), 64'd0);
    check({tag, "_near"}, m_near, e_near);
    check({tag, "_far"}, m_far, e_far);
    check({tag, "_mid"}, m_mid, e_mid);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, 64'(m_done), 64'd0);
    check({tag, "_busy_after"}, 64'(m_busy), 64'd0);
    check({tag, "_mid_held"}, m_mid, e_mid);
  endtask

  initial begin
    int n;
    int span;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; size = '0; sel = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    sel = 0; check_idle_zero("reset_l1");
    sel = 1; check_idle_zero("reset_l3");
    rst = 1'b0;

    mem[0] = pt(257, -42, -155);   mem[1] = pt(272, -45, -155);
    mem[2] = pt(-993, -154, -154); mem[3] = pt(-286, -45, -155);
    mem[4] = pt(-1325, -218, -157); mem[5] = pt(-302, -49, -154);
    mem[6] = pt(-1640, -271, -155);
    run_scan(0, 7, 0, 0, "nominal");
    check("nominal_near_const", m_near, {16'(-1640), 16'(-271), 16'(-157), 16'h0});
    check("nominal_far_const",  m_far,  {16'(272), 16'(-42), 16'(-154), 16'h0});
    check("nominal_mid_const",  m_mid,  {16'(-684), 16'(-157), 16'(-156), 16'h0});

    mem[0] = pt(-10113, 7985, -441); mem[1] = pt(5557, -7972, 315);
    run_scan(0, 2, 0, 0, "rounding");
    check("rounding_mid_const", m_mid, {16'(-2278), 16'(6), 16'(-63), 16'h0});

    mem[0] = pt(-32768, -32768, -32768); mem[1] = pt(32767, 32767, 32767);
    run_scan(0, 2, 0, 0, "extremes_l1");
    check("extremes_l1_mid_const", m_mid, {16'hffff, 16'hffff, 16'hffff, 16'h0});
    run_scan(1, 2, 0, 0, "extremes_l3");
    check("extremes_l3_mid_const", m_mid, {16'hffff, 16'hffff, 16'hffff, 16'h0});

    mem[0] = pt(5, -5, 0);
    run_scan(0, 1, 0, 0, "single_l1");
    run_scan(1, 1, 0, 0, "single_l3");
    check("single_mid_const", m_mid, {16'(5), 16'(-5), 16'(0), 16'h0});
    run_scan(0, 0, 0, 0, "empty_l1");
    run_scan(1, 0, 0, 0, "empty_l3");

    for (int i = 0; i < 10; i++) mem[i] = {16'($urandom), $urandom};
    run_scan(0, 10, 3, 0, "restart_ignored_l1");
    run_scan(1, 10, 3, 0, "restart_ignored_l3");

    for (int i = 0; i < 8; i++) mem[i] = pt(-30000 + i, -30000, -30000);
    run_scan(1, 8, 0, 3, "rst_mid_scan");
    for (int i = 0; i < 6; i++) mem[i] = pt($urandom_range(100, 200), $urandom_range(0, 9), 1000 - i);
    run_scan(1, 6, 0, 0, "fresh_after_rst");

    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 40);
      span = (f % 2 == 0) ? 65535 : 7;
      for (int i = 0; i < n; i++) begin
        mem[i] = pt(int'($urandom_range(0, span)) - 32768 + int'($urandom_range(0, 32767)),
                    int'($urandom_range(0, span)) - span / 2,
                    int'($urandom_range(0, 65535)) - 32768);
      end
      run_scan(f % 2, n, 0, 0, $sformatf("random%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/point_cloud_bbox.md
# point_cloud_bbox

Upstream pre-processing stage for the octree builder. It reads one frame of 16-bit fixed-point points from a point BRAM and computes the axis-aligned bounding box. It then produces the packed `near_bottom_left`, `far_top_right` and `mid_point` words that the octree core consumes on `i_near_bottom_left`, `i_far_top_right` and `i_mid_point`. Its `o_done` pulse is the octree core's cue to start (`i_en`).

## Interface
- `RD_LATENCY`, 1: BRAM read latency in cycles, legal range 1–3.
- `ADDR_W`, 16: BRAM address width.
- `SIZE_W`, 16: width of the point-count input.
- `i_clk` in 1: the block's only clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: single-cycle request to scan a frame; sampled only in IDLE.
- `i_point_cloud_size` in SIZE_W: number of points N, sampled with `i_start`.
- `o_rd_en` out 1: BRAM read enable.
- `o_rd_addr` out ADDR_W: BRAM read address.
- `i_rd_data` in 48: point data from BRAM as {x[47:32], y[31:16], z[15:0]}, signed two's complement.
- `o_near_bottom_left` out 64: {xmin, ymin, zmin, 16'h0000}.
- `o_far_top_right` out 64: {xmax, ymax, zmax, 16'h0000}.
- `o_mid_point` out 64: {xmid, ymid, zmid, 16'h0000}.
- `o_busy` out 1: high from the cycle after start is accepted until the cycle `o_done` is asserted (inclusive).
- `o_done` out 1: single-cycle pulse; the three 64-bit outputs are valid from this cycle until the next accepted start.

## Operation
- States: IDLE, READ, DRAIN, MID, DONE.
- **IDLE**
  - `i_start` = 1 and N > 0: latch N, clear the address counter, go to READ.
  - `i_start` = 1 and N = 0: go directly to DONE. All outputs are zero.
- **READ**
  - Assert `o_rd_en` with `o_rd_addr` = 0, 1, …, N-1, one address per cycle.
  - After issuing N-1, go to DRAIN.
- **DRAIN**
  - Wait until all RD_LATENCY outstanding reads have returned, then go to MID.
- **Data handling**
  - A valid-tag shift register of depth RD_LATENCY follows `o_rd_en`.
  - When the tag emerges, `i_rd_data` is sampled and folded into the per-axis min/max registers.
  - The first returned point loads min = max = point directly. Reset values are never compared.
  - Subsequent points use signed compares. Ties leave the register unchanged.
- **MID** (one cycle)
  - Per axis: mid = (min + max) >>> 1.
  - The sum is computed as a 17-bit sign-extended add, so it cannot overflow.
  - The arithmetic shift rounds toward −∞. Bits [15:0] of the result are kept.
- **DONE** (one cycle)
  - Drive `o_done` = 1, register the outputs, return to IDLE.
- `i_start` outside IDLE is ignored. `i_point_cloud_size` changes outside the start cycle have no effect.
- **Reset**
  - At any time, including mid-scan, reset forces IDLE.
  - It clears all outputs to 0: `o_rd_en`, `o_rd_addr`, `o_busy`, `o_done`, all three 64-bit words, and the tag pipeline.
  - Data returned by the BRAM after reset is discarded.
- The low 16 bits of every 64-bit output are always 0.

## Timing
- Start sampled at edge E0 with N > 0:
  - `o_rd_en` is high for exactly N consecutive cycles, from E0+1 through E0+N.
  - The read at cycle k returns data in cycle k+RD_LATENCY; the min/max registers update at the end of that cycle.
  - The MID cycle is at E0+N+RD_LATENCY+1.
  - `o_done` is high in cycle E0+N+RD_LATENCY+2.
- Start sampled at E0 with N = 0: `o_done` is high in cycle E0+1.
- Earliest next accepted start is the cycle after `o_done`. Throughput is one point per cycle.
- `o_rd_addr` holds its last value while `o_rd_en` = 0. Its value is irrelevant when `o_rd_en` = 0.

## Test plan
- **Nominal frame**, N=7, RD_LATENCY=1. Points (257,-42,-155), (272,-45,-155), (-993,-154,-154), (-286,-45,-155), (-1325,-218,-157), (-302,-49,-154), (-1640,-271,-155). Required:
  - near = {-1640, -271, -157, 0}
  - far = {272, -42, -154, 0}
  - mid = {-684, -157, -156, 0}
  - `o_done` at E0+10.
- **Mid rounding**: bbox corners (-10113,-7972,-441) and (5557,7985,315) -> mid = {-2278, 6, -63, 0}.
- **Extremes**: points (-32768,-32768,-32768) and (32767,32767,32767) -> mid = {-1, -1, -1, 0} with no overflow. Repeat with RD_LATENCY=3; `o_done` at E0+7.
- **Degenerate sizes**:
  - N=1, point (5,-5,0): near = far = mid = {5, -5, 0, 0}.
  - N=0: `o_done` at E0+1, all outputs zero, `o_rd_en` never asserted.
- **Protocol robustness**:
  - `i_start` pulsed during READ is ignored; the result and address count match a single scan.
  - `i_rst` asserted at the 3rd read cycle: next cycle all outputs are 0 and the state is IDLE.
  - A fresh start after reset produces correct results with no stale min/max.
